// File: rtl/methane_pkg.sv
// Shared types and constants for the methane voice path.
// Holds the ADSR stage encoding and the default envelope CV width.
package methane_pkg;

    localparam int ADSR_CV_W = 16;
    localparam logic [ADSR_CV_W-1:0] ADSR_CV_MAX = '1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } adsr_stage_e;

endpackage

// File: rtl/adsr_envelope_if.sv
// Note-event, envelope-setting and CV-output bundle between the note source and the ADSR.
// The master drives notes and settings; the slave (envelope) drives the CV side.
interface adsr_if
    import methane_pkg::*;
#(
    parameter int CV_W = ADSR_CV_W
) ();

    logic            note_on;
    logic            note_off;
    logic [CV_W-1:0] attack_rate;
    logic [CV_W-1:0] decay_rate;
    logic [CV_W-1:0] sustain_level;
    logic [CV_W-1:0] release_rate;
    logic [CV_W-1:0] adsr_cv;
    adsr_stage_e     stage;
    logic            cv_valid;
    logic            busy;

    modport master (
        output note_on, note_off, attack_rate, decay_rate, sustain_level, release_rate,
        input  adsr_cv, stage, cv_valid, busy
    );

    modport slave (
        input  note_on, note_off, attack_rate, decay_rate, sustain_level, release_rate,
        output adsr_cv, stage, cv_valid, busy
    );

endinterface

// File: rtl/tick_gen.sv
// Free-running prescaler: one-cycle tick every DIV clocks, on count DIV-1.
// Shared by the envelope and LFO stages.
module tick_gen #(
    parameter int DIV = 1024
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/adsr_envelope.sv
// Linear ADSR envelope generator: note edges steer the stage, prescaled ticks step the level.
// Events win over a coincident tick; that tick's level update is then dropped.
module adsr_envelope
    import methane_pkg::*;
#(
    parameter int CV_W     = ADSR_CV_W,
    parameter int TICK_DIV = 1024
) (
    input  logic  clk_in_50M,
    input  logic  rst,
    adsr_if.slave bus
);

    localparam logic [CV_W-1:0] CV_MAX = '1;

    logic            tick;
    logic            note_on_q;
    logic            note_off_q;
    logic [CV_W-1:0] level;
    adsr_stage_e     stage_q;
    logic            cv_valid_q;

    logic            on_evt;
    logic            off_evt;
    logic [CV_W:0]   attack_sum;
    logic [CV_W-1:0] attack_next;
    logic [CV_W-1:0] decay_next;
    logic [CV_W-1:0] release_next;

    tick_gen #(.DIV(TICK_DIV)) u_tick_gen (
        .clk   (clk_in_50M),
        .rst_n (rst),
        .tick  (tick)
    );

    // NOTE: every output of this block is assigned on every path, so no latch can be inferred.
    always_comb begin
        on_evt      = bus.note_on & ~note_on_q;
        off_evt     = bus.note_off & ~note_off_q & (stage_q inside {ATTACK, DECAY, SUSTAIN});

        // One extra bit catches the overflow that saturates the attack.
        attack_sum  = {1'b0, level} + {1'b0, bus.attack_rate};
        attack_next = (bus.attack_rate == '0 || attack_sum[CV_W]) ? CV_MAX : attack_sum[CV_W-1:0];

        if (bus.decay_rate == '0 || level < bus.decay_rate ||
            (level - bus.decay_rate) <= bus.sustain_level) begin
            decay_next = bus.sustain_level;
        end else begin
            decay_next = level - bus.decay_rate;
        end

        release_next = (bus.release_rate == '0 || level <= bus.release_rate) ? '0
                                                                             : level - bus.release_rate;
    end

    always_ff @(posedge clk_in_50M or negedge rst) begin
        if (!rst) begin
            note_on_q  <= 1'b0;
            note_off_q <= 1'b0;
            level      <= '0;
            stage_q    <= IDLE;
            cv_valid_q <= 1'b0;
        end else begin
            note_on_q  <= bus.note_on;
            note_off_q <= bus.note_off;
            cv_valid_q <= 1'b0;
            if (on_evt) begin
                stage_q <= ATTACK;
            end else if (off_evt) begin
                stage_q <= RELEASE;
            end else if (tick) begin
                cv_valid_q <= 1'b1;
                case (stage_q)
                    IDLE: level <= '0;
                    ATTACK: begin
                        level <= attack_next;
                        if (attack_next == CV_MAX) stage_q <= DECAY;
                    end
                    DECAY: begin
                        level <= decay_next;
                        if (decay_next == bus.sustain_level) stage_q <= SUSTAIN;
                    end
                    SUSTAIN: level <= bus.sustain_level;
                    RELEASE: begin
                        level <= release_next;
                        if (release_next == '0) stage_q <= IDLE;
                    end
                    default: begin
                        level   <= '0;
                        stage_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.adsr_cv  = level;
    assign bus.stage    = stage_q;
    assign bus.cv_valid = cv_valid_q;
    assign bus.busy     = (stage_q != IDLE);

endmodule

// File: tb/tb_adsr_envelope.sv
// Self-checking bench for adsr_envelope: directed envelope scenarios plus randomized
// note/setting traffic compared every cycle against an arithmetic envelope model.
module tb_adsr_envelope;
    import methane_pkg::*;

    localparam int CV_W     = 16;
    localparam int TICK_DIV = 4;
    localparam int MAX      = int'(ADSR_CV_MAX);

    logic clk = 1'b0;
    logic rst;

    adsr_if #(.CV_W(CV_W)) bus ();

    adsr_envelope #(.CV_W(CV_W), .TICK_DIV(TICK_DIV)) dut (
        .clk_in_50M (clk),
        .rst        (rst),
        .bus        (bus)
    );

    always #10 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference envelope state, stepped once per clock edge.
    int m_level;
    int m_stage;
    int m_cnt;
    bit m_prev_on;
    bit m_prev_off;
    bit m_valid;

    logic [15:0] seen[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_level    = 0;
        m_stage    = 0;
        m_cnt      = 0;
        m_prev_on  = 1'b0;
        m_prev_off = 1'b0;
        m_valid    = 1'b0;
    endfunction

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic void model_step();
        bit on, off, tk;
        int ar, dr, sl, rr;
        on  = bus.note_on && !m_prev_on;
        off = bus.note_off && !m_prev_off && (m_stage >= 1) && (m_stage <= 3);
        m_prev_on  = bus.note_on;
        m_prev_off = bus.note_off;
        tk    = (m_cnt == TICK_DIV - 1);
        m_cnt = (m_cnt + 1) % TICK_DIV;
        ar = int'(bus.attack_rate);
        dr = int'(bus.decay_rate);
        sl = int'(bus.sustain_level);
        rr = int'(bus.release_rate);
        m_valid = 1'b0;
        if (on) begin
            m_stage = 1;
        end else if (off) begin
            m_stage = 4;
        end else if (tk) begin
            m_valid = 1'b1;
            case (m_stage)
                0: m_level = 0;
                1: begin
                    m_level = (ar == 0) ? MAX : imin(m_level + ar, MAX);
                    if (m_level == MAX) m_stage = 2;
                end
                2: begin
                    m_level = (dr == 0) ? sl : imax(m_level - dr, sl);
                    if (m_level == sl) m_stage = 3;
                end
                3: m_level = sl;
                default: begin
                    m_level = (rr == 0) ? 0 : imax(m_level - rr, 0);
                    if (m_level == 0) m_stage = 0;
                end
            endcase
        end
    endfunction

    // One clock: model follows the edge, outputs compared 1 ns later, return on the falling edge.
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check("cv", bus.adsr_cv, m_level);
        check("stage", bus.stage, m_stage);
        check("valid", bus.cv_valid, m_valid);
        check("busy", bus.busy, m_stage != 0);
        @(negedge clk);
    endtask

    task automatic wait_stage(input int target, input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            cycle();
            if (bus.cv_valid) seen.push_back(bus.adsr_cv);
            if (bus.stage == target) break;
        end
        check(tag, bus.stage, target);
    endtask

    task automatic wait_valid(input int budget, input string tag, input int exp);
        bit found = 1'b0;
        logic [15:0] v = '0;
        for (int i = 0; i < budget && !found; i++) begin
            cycle();
            if (bus.cv_valid) begin
                found = 1'b1;
                v     = bus.adsr_cv;
            end
        end
        check({tag, "_tick"}, found, 1);
        check(tag, v, exp);
    endtask

    task automatic set_rates(input int ar, input int dr, input int sl, input int rr);
        bus.attack_rate   = 16'(ar);
        bus.decay_rate    = 16'(dr);
        bus.sustain_level = 16'(sl);
        bus.release_rate  = 16'(rr);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cv"}, bus.adsr_cv, 0);
        check({tag, "_stage"}, bus.stage, IDLE);
        check({tag, "_valid"}, bus.cv_valid, 0);
        check({tag, "_busy"}, bus.busy, 0);
    endtask

    function automatic logic [15:0] rnd_rate();
        case ($urandom_range(0, 3))
            0:       return 16'h0000;
            1:       return 16'($urandom_range(1, 255));
            2:       return 16'($urandom_range(256, 4095));
            default: return 16'($urandom_range(4096, 65535));
        endcase
    endfunction

    initial begin
        #5ms;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst          = 1'b0;
        bus.note_on  = 1'b0;
        bus.note_off = 1'b0;
        set_rates(16'h4000, 16'h1000, 16'h8000, 16'h2000);
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");

        // Full cycle: note_on held through reset release and for three clocks.
        bus.note_on = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        seen.delete();
        repeat (3) begin
            cycle();
            if (bus.cv_valid) seen.push_back(bus.adsr_cv);
        end
        bus.note_on = 1'b0;
        check("trig_stage", bus.stage, ATTACK);
        wait_stage(SUSTAIN, 200, "full_sustain");
        check("full_ticks", seen.size(), 12);
        if (seen.size() == 12) begin
            check("att1", seen[0], 16'h4000);
            check("att2", seen[1], 16'h8000);
            check("att3", seen[2], 16'hC000);
            check("att4", seen[3], 16'hFFFF);
            check("dec1", seen[4], 16'hEFFF);
            check("dec8", seen[11], 16'h8000);
        end

        // Release from SUSTAIN at 0x8000.
        bus.release_rate = 16'h2000;
        bus.note_off = 1'b1;
        cycle();
        bus.note_off = 1'b0;
        check("rel_stage", bus.stage, RELEASE);
        check("rel_hold", bus.adsr_cv, 16'h8000);
        seen.delete();
        wait_stage(IDLE, 100, "rel_idle");
        check("rel_ticks", seen.size(), 4);
        if (seen.size() == 4) begin
            check("rel1", seen[0], 16'h6000);
            check("rel2", seen[1], 16'h4000);
            check("rel3", seen[2], 16'h2000);
            check("rel4", seen[3], 16'h0000);
        end
        check("rel_busy", bus.busy, 0);

        // Retrigger during RELEASE at 0x6000.
        bus.note_on = 1'b1;
        cycle();
        bus.note_on = 1'b0;
        wait_stage(SUSTAIN, 200, "c_sustain");
        bus.note_off = 1'b1;
        cycle();
        bus.note_off = 1'b0;
        wait_valid(20, "c_rel", 16'h6000);
        bus.note_on = 1'b1;
        cycle();
        bus.note_on = 1'b0;
        check("retrig_stage", bus.stage, ATTACK);
        check("retrig_hold", bus.adsr_cv, 16'h6000);
        wait_valid(20, "retrig_lvl", 16'hA000);

        // Simultaneous on/off in SUSTAIN, then zero rates.
        wait_stage(SUSTAIN, 200, "d_sustain");
        bus.note_on  = 1'b1;
        bus.note_off = 1'b1;
        cycle();
        bus.note_on  = 1'b0;
        bus.note_off = 1'b0;
        check("both_stage", bus.stage, ATTACK);
        set_rates(0, 0, 16'h3000, 0);
        wait_valid(20, "z_att", 16'hFFFF);
        check("z_att_stage", bus.stage, DECAY);
        wait_valid(20, "z_dec", 16'h3000);
        check("z_dec_stage", bus.stage, SUSTAIN);
        bus.note_off = 1'b1;
        cycle();
        bus.note_off = 1'b0;
        check("z_rel_stage", bus.stage, RELEASE);
        wait_valid(20, "z_rel", 0);
        check("z_rel_idle", bus.stage, IDLE);
        check("z_rel_busy", bus.busy, 0);
        bus.note_off = 1'b1;
        cycle();
        bus.note_off = 1'b0;
        check("off_idle_stage", bus.stage, IDLE);
        check("off_idle_cv", bus.adsr_cv, 0);
        n = 0;
        repeat (40) begin
            cycle();
            if (bus.cv_valid) n++;
        end
        check("valid_rate", n, 40 / TICK_DIV);

        // Randomized traffic with one asynchronous reset in the middle.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) bus.note_on = ~bus.note_on;
            if ($urandom_range(0, 9) == 0) bus.note_off = ~bus.note_off;
            if ($urandom_range(0, 63) == 0) begin
                bus.attack_rate  = rnd_rate();
                bus.decay_rate   = rnd_rate();
                bus.release_rate = rnd_rate();
            end
            if ($urandom_range(0, 31) == 0) bus.sustain_level = 16'($urandom);
            if (i == 1500) begin
                #2;
                rst = 1'b0;
                #1;
                check_reset_outputs("async_reset");
                model_reset();
                @(negedge clk);
                check_reset_outputs("reset_hold");
                rst = 1'b1;
            end
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adsr_envelope.md
Name: adsr_envelope

Overview:
Linear ADSR envelope generator for the methane voice path. Sits directly downstream of the note-event source (debug_note_on / debug_note_off in Top) and produces the 16-bit envelope CV that Top exports as debug_adsr_cv and that feeds the VCA stage. Envelope updates at a prescaled sample tick derived from the 50 MHz system clock.

Parameters:
CV_W, 16, envelope/CV width in bits
TICK_DIV, 1024, system clocks per envelope tick (50 MHz / 1024 ≈ 48.8 kHz); must be >= 2

Ports:
clk_in_50M  input  1  system clock, 50 MHz
rst  input  1  asynchronous, active-low reset (asserted when 0)
note_on  input  1  note-on request; level, may be held several cycles; synchronous to clk_in_50M
note_off  input  1  note-off request; same rules as note_on
attack_rate  input  CV_W  level increment per tick in ATTACK; 0 = instant
decay_rate  input  CV_W  level decrement per tick in DECAY; 0 = instant
sustain_level  input  CV_W  SUSTAIN target level
release_rate  input  CV_W  level decrement per tick in RELEASE; 0 = instant
adsr_cv  output  CV_W  current envelope level (registered)
stage  output  3  current stage (adsr_stage_e)
cv_valid  output  1  one-cycle pulse when adsr_cv has just been updated by a tick
busy  output  1  high whenever stage != IDLE

Behaviour:
- Reset (rst=0, async): adsr_cv=0, stage=IDLE, cv_valid=0, busy=0, prescaler=0, edge-detect history=0. Held note_on across reset release produces one trigger on the first clock.
- Edge detect: on_evt = note_on & ~note_on_q; off_evt likewise. A held level produces exactly one event.
- Events act on the next clock edge, independent of tick: stage changes 1 clock after input rises; level unchanged by the event itself.
- Event rules: on_evt in any stage -> ATTACK (retrigger from current level, no reset to 0). off_evt in ATTACK/DECAY/SUSTAIN -> RELEASE; in IDLE/RELEASE ignored. on_evt and off_evt same cycle -> on_evt wins.
- Prescaler counts 0..TICK_DIV-1; tick on TICK_DIV-1, then wraps to 0. Rate/sustain inputs sampled live at each tick.
- On tick (events in same cycle take priority; level update skipped that cycle):
  IDLE: level held at 0.
  ATTACK: level = min(level+attack_rate, 2^CV_W-1) computed CV_W+1 bits wide; rate 0 -> max. At max -> DECAY.
  DECAY: level = max(level-decay_rate, sustain_level), no underflow; rate 0 -> sustain_level. At sustain_level -> SUSTAIN.
  SUSTAIN: level = sustain_level (tracks live changes).
  RELEASE: level = max(level-release_rate, 0); rate 0 -> 0. At 0 -> IDLE.
- Stage transition decided on the same tick that reaches the target; adsr_cv and stage update together.
- cv_valid pulses for 1 cycle, aligned with the cycle adsr_cv shows the new tick value (every tick, including IDLE).
- sustain_level above current level on entering DECAY: level jumps to sustain_level on first tick (max clamp), -> SUSTAIN.

Decomposition:
- methane_pkg: adsr_stage_e (IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4), ADSR_CV_W=16, ADSR_CV_MAX.
- Sub-module tick_gen (parameter DIV; outputs 1-cycle tick; same clock/reset) for the prescaler, reusable by LFO stages.

Test Plan:
- Reset: drive rst=0 mid-run with any state -> adsr_cv=0, stage=IDLE, cv_valid=0, busy=0 immediately (async).
- Full cycle, TICK_DIV=4, attack=0x4000, decay=0x1000, sustain=0x8000: note_on held 3 clocks -> one trigger; ticks give 0x4000,0x8000,0xC000,0xFFFF -> DECAY; 8 ticks later 0x8000 -> SUSTAIN.
- Release: in SUSTAIN at 0x8000, release=0x2000, note_off -> RELEASE next clock; ticks 0x6000,0x4000,0x2000,0x0000 -> IDLE, busy=0.
- Retrigger: note_on while RELEASE at 0x6000 -> ATTACK, next tick 0xA000 (attack 0x4000), no drop to 0.
- Simultaneous note_on/note_off rising same clock in SUSTAIN -> ATTACK; note_off alone in IDLE -> stays IDLE, adsr_cv=0.
- Zero rates: attack=0 -> first tick 0xFFFF; decay=0 -> next tick sustain_level; release=0 -> next tick 0 and IDLE; cv_valid one pulse per tick throughout.
